ras_ctrl: RTL and testbench

- Return-address-stack controller for the fetch stage.
- Holds the speculative RAS and supplies top-of-stack to the fetch-bundle branch decoder on ras_data.
- Applies that decoder's per-bundle ras_ctrl/ras_data (push/pop/coroutine) and exposes a checkpoint per bundle.
- Restores the checkpoint on branch-mispredict recovery, and clears the stack on flush via a multi-cycle sweep.

---
 rtl/ras_ctrl.sv | 112 +++++++++++
 tb/tb_ras_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// Speculative return-address stack for the fetch stage: push/pop/coroutine ops,
// per-bundle checkpoint out, checkpoint restore on mispredict, swept clear on flush.
module ras_ctrl #(
   parameter int DEPTH = 8,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 op_valid_i,
   input  logic [1:0]           ras_op_i,
   input  logic [63:0]          push_pc_i,
   output logic [63:0]          top_data_o,
   output logic [PW+CW+63:0]    ckpt_o,
   input  logic                 recover_i,
   input  logic [PW+CW+63:0]    ckpt_i,
   input  logic                 flush_i,
   output logic                 ready_o,
   output logic                 overflow_o,
   output logic                 underflow_o
);

   typedef enum logic {IDLE, CLEAR} state_e;

   state_e                  state_q;
   logic [DEPTH-1:0][63:0]  stack_q;
   logic [PW-1:0]           tos_q;
   logic [PW-1:0]           clr_idx_q;
   logic [CW-1:0]           cnt_q;
   logic                    ovf_q;
   logic                    unf_q;

   logic          empty, full, do_push, do_pop, do_swap;
   logic [PW-1:0] tos_inc, tos_dec;
   logic [63:0]   ret_addr;
   logic [PW-1:0] ck_tos;
   logic [CW-1:0] ck_cnt;
   logic [63:0]   ck_top;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == CW'(DEPTH));
   assign tos_inc  = tos_q + PW'(1);
   assign tos_dec  = tos_q - PW'(1);
   assign ret_addr = push_pc_i + 64'd4;

   // A coroutine on an empty stack degenerates to a plain push.
   assign do_push = op_valid_i && ((ras_op_i == 2'b01) || (ras_op_i == 2'b11 && empty));
   assign do_pop  = op_valid_i && (ras_op_i == 2'b10);
   assign do_swap = op_valid_i && (ras_op_i == 2'b11) && !empty;

   assign ck_tos = ckpt_i[PW+CW+63 -: PW];
   assign ck_cnt = ckpt_i[CW+63 -: CW];
   assign ck_top = ckpt_i[63:0];

   assign top_data_o  = empty ? 64'd0 : stack_q[tos_q];
   assign ckpt_o      = {tos_q, cnt_q, top_data_o};
   assign ready_o     = (state_q == IDLE);
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         stack_q   <= '0;
         tos_q     <= '0;
         clr_idx_q <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         if (flush_i) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            tos_q     <= '0;
            cnt_q     <= '0;
         end else begin
            case (state_q)
               CLEAR: begin
                  stack_q[clr_idx_q] <= '0;
                  clr_idx_q          <= clr_idx_q + PW'(1);
                  if (clr_idx_q == PW'(DEPTH - 1)) state_q <= IDLE;
               end
               IDLE: begin
                  if (recover_i) begin
                     // Rewriting the top slot undoes a coroutine/push overwrite.
                     tos_q <= ck_tos;
                     cnt_q <= ck_cnt;
                     if (ck_cnt != '0) stack_q[ck_tos] <= ck_top;
                  end else if (do_push) begin
                     tos_q            <= tos_inc;
                     stack_q[tos_inc] <= ret_addr;
                     if (full) ovf_q <= 1'b1;
                     else      cnt_q <= cnt_q + CW'(1);
                  end else if (do_pop) begin
                     if (empty) unf_q <= 1'b1;
                     else begin
                        tos_q <= tos_dec;
                        cnt_q <= cnt_q - CW'(1);
                     end
                  end else if (do_swap) begin
                     stack_q[tos_q] <= ret_addr;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against an abstract stack model.
`timescale 1ns/1ps
module tb_ras_ctrl;
   localparam int DEPTH = 8;
   localparam int PW    = 3;
   localparam int CW    = 4;
   localparam int CKW   = PW + CW + 64;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           op_valid = 1'b0;
   logic [1:0]     ras_op = 2'b00;
   logic [63:0]    push_pc = '0;
   logic [63:0]    top_data;
   logic [CKW-1:0] ckpt_o;
   logic           recover = 1'b0;
   logic [CKW-1:0] ckpt_i = '0;
   logic           flush = 1'b0;
   logic           ready, overflow, underflow;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ras_ctrl #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .op_valid_i(op_valid), .ras_op_i(ras_op),
      .push_pc_i(push_pc), .top_data_o(top_data), .ckpt_o(ckpt_o),
      .recover_i(recover), .ckpt_i(ckpt_i), .flush_i(flush), .ready_o(ready),
      .overflow_o(overflow), .underflow_o(underflow));

   // Abstract model: circular slot array, integer pointer/occupancy, and
   // a countdown of remaining clear cycles (nonzero means not ready).
   logic [63:0] m_mem [DEPTH];
   int m_tos, m_cnt, m_clr, m_cidx;
   bit m_ovf, m_unf;

   function automatic logic [63:0] m_top();
      return (m_cnt != 0) ? m_mem[m_tos] : 64'd0;
   endfunction

   function automatic logic [CKW-1:0] m_ckpt();
      return {PW'(m_tos), CW'(m_cnt), m_top()};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_tos = 0; m_cnt = 0; m_clr = 0; m_cidx = 0; m_ovf = 0; m_unf = 0;
   endtask

   task automatic m_push(input logic [63:0] pc);
      if (m_cnt == DEPTH) m_ovf = 1;
      else m_cnt++;
      m_tos = (m_tos + 1) % DEPTH;
      m_mem[m_tos] = pc + 64'd4;
   endtask

   task automatic model_step();
      m_ovf = 0; m_unf = 0;
      if (flush) begin
         m_clr = DEPTH; m_cidx = 0; m_tos = 0; m_cnt = 0;
      end else if (m_clr > 0) begin
         m_mem[m_cidx] = '0; m_cidx++; m_clr--;
      end else if (recover) begin
         m_tos = int'(ckpt_i[CKW-1 -: PW]);
         m_cnt = int'(ckpt_i[CW+63 -: CW]);
         if (m_cnt != 0) m_mem[m_tos] = ckpt_i[63:0];
      end else if (op_valid) begin
         case (ras_op)
            2'b01: m_push(push_pc);
            2'b10: if (m_cnt == 0) m_unf = 1;
                   else begin m_tos = (m_tos + DEPTH - 1) % DEPTH; m_cnt--; end
            2'b11: if (m_cnt == 0) m_push(push_pc);
                   else m_mem[m_tos] = push_pc + 64'd4;
            default: ;
         endcase
      end
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("top", 128'(top_data), 128'(m_top()));
         chk("ckpt", 128'(ckpt_o), 128'(m_ckpt()));
         chk("ready", 128'(ready), 128'(m_clr == 0));
         chk("ovf", 128'(overflow), 128'(m_ovf));
         chk("unf", 128'(underflow), 128'(m_unf));
      end
   end

   // Advance one clock; returns at negedge+1 so inputs change away from both edges.
   task automatic step();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_op(input logic [1:0] op, input logic [63:0] pc);
      op_valid = 1'b1; ras_op = op; push_pc = pc;
      step();
      op_valid = 1'b0; ras_op = 2'b00;
   endtask

   function automatic logic [127:0] cnt_of(input logic [CKW-1:0] c);
      return 128'(c[CW+63 -: CW]);
   endfunction

   function automatic logic [127:0] tos_of(input logic [CKW-1:0] c);
      return 128'(c[CKW-1 -: PW]);
   endfunction

   task automatic count_low(input string nm);
      int n = 0;
      while (!ready && n < 20) begin
         do_op(2'b01, 64'h0000_0000_DEAD_0000);
         n++;
      end
      chk(nm, 128'(n), 128'(DEPTH));
   endtask

   logic [CKW-1:0] saved;
   logic [CKW-1:0] hist [$];

   initial begin
      #1 rst_n = 1'b0;
      model_reset();
      #1 chk_en = 1'b1;
      step(); step();
      chk("rst_top", 128'(top_data), 128'd0);
      chk("rst_ready", 128'(ready), 128'd1);
      chk("rst_ovf", 128'(overflow), 128'd0);
      rst_n = 1'b1;
      step();

      do_op(2'b01, 64'h1000); do_op(2'b01, 64'h2000); do_op(2'b01, 64'h3000);
      chk("push3_top", 128'(top_data), 128'h3004);
      chk("push3_cnt", cnt_of(ckpt_o), 128'd3);
      do_op(2'b10, '0);
      chk("pop1_top", 128'(top_data), 128'h2004);
      do_op(2'b10, '0); do_op(2'b10, '0);
      chk("pop3_top", 128'(top_data), 128'd0);
      do_op(2'b10, '0);
      chk("unf_pulse", 128'(underflow), 128'd1);
      chk("unf_tos", tos_of(ckpt_o), 128'd0);
      step();
      chk("unf_clear", 128'(underflow), 128'd0);

      for (int k = 1; k <= 9; k++) do_op(2'b01, 64'(k * 'h100));
      chk("ovf_pulse", 128'(overflow), 128'd1);
      chk("ovf_cnt", cnt_of(ckpt_o), 128'd8);
      chk("ovf_top", 128'(top_data), 128'h904);
      for (int k = 1; k <= 8; k++) begin
         chk("ovf_pop_top", 128'(top_data), 128'(64'((10 - k) * 'h100 + 4)));
         do_op(2'b10, '0);
      end
      do_op(2'b10, '0);
      chk("ovf_unf", 128'(underflow), 128'd1);

      do_op(2'b01, 64'h1000); do_op(2'b01, 64'h2000);
      saved = ckpt_o;
      chk("ck_top", 128'(top_data), 128'h2004);
      do_op(2'b11, 64'h5000);
      chk("co_top", 128'(top_data), 128'h5004);
      do_op(2'b01, 64'h6000);
      chk("co_push_top", 128'(top_data), 128'h6004);
      recover = 1'b1; ckpt_i = saved;
      step();
      recover = 1'b0;
      chk("rec_top", 128'(top_data), 128'h2004);
      chk("rec_cnt", cnt_of(ckpt_o), 128'd2);
      chk("rec_tos", tos_of(ckpt_o), tos_of(saved));
      do_op(2'b10, '0);
      chk("rec_below", 128'(top_data), 128'h1004);

      saved = ckpt_o;
      do_op(2'b01, 64'h7000);
      recover = 1'b1; ckpt_i = saved;
      do_op(2'b01, 64'h8000);
      recover = 1'b0;
      chk("rec_push_top", 128'(top_data), 128'h1004);
      chk("rec_push_cnt", cnt_of(ckpt_o), 128'd1);

      do_op(2'b01, 64'hA000); do_op(2'b01, 64'hB000); do_op(2'b01, 64'hC000);
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_ready", 128'(ready), 128'd0);
      count_low("flush_low_cycles");
      chk("flush_cnt", cnt_of(ckpt_o), 128'd0);

      do_op(2'b11, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_top", 128'(top_data), 128'd0);
      chk("wrap_cnt", cnt_of(ckpt_o), 128'd1);
      chk("wrap_unf", 128'(underflow), 128'd0);

      flush = 1'b1; step(); flush = 1'b0;
      step(); step();
      flush = 1'b1; step(); flush = 1'b0;
      count_low("reflush_low_cycles");

      flush = 1'b1; step(); flush = 1'b0;
      step(); step();
      rst_n = 1'b0; model_reset();
      #1 chk("midclr_rst_ready", 128'(ready), 128'd1);
      step(); rst_n = 1'b1; step();

      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         op_valid = ($urandom_range(0, 3) != 0);
         ras_op   = 2'($urandom_range(0, 3));
         push_pc  = {$urandom, $urandom};
         flush    = (r < 2);
         recover  = (r >= 2 && r < 10);
         if (recover) begin
            if (hist.size() > 0 && r < 7) ckpt_i = hist[$urandom_range(0, hist.size() - 1)];
            else ckpt_i = {PW'($urandom), CW'($urandom_range(0, DEPTH)), {$urandom, $urandom}};
         end
         if ($urandom_range(0, 4) == 0) begin
            hist.push_back(ckpt_o);
            if (hist.size() > 16) void'(hist.pop_front());
         end
         step();
      end
      op_valid = 1'b0; flush = 1'b0; recover = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
